exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 46 ++++
 rtl/exc_ctrl_if.sv | 46 ++++
 rtl/exc_ctrl_slot.sv | 47 ++++
 rtl/exc_ctrl.sv | 125 ++++++++++++
 tb/tb_exc_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared CPU parameters for exception control: ExcCode values, handler vector,
// reset PC seed and the take/eret FSM encoding.
package exc_ctrl_pkg;

    localparam int          CODE_W_DEF  = 5;

    localparam logic [4:0]  EXC_INT     = 5'd0;
    localparam logic [4:0]  EXC_ADEL    = 5'd4;
    localparam logic [4:0]  EXC_ADES    = 5'd5;
    localparam logic [4:0]  EXC_SYSCALL = 5'd8;
    localparam logic [4:0]  EXC_RI      = 5'd10;
    localparam logic [4:0]  EXC_OV      = 5'd12;

    localparam logic [31:0] EXC_VEC_DEF = 32'h0000_4180;
    localparam logic [31:0] LAST_PC_RST = 32'h0000_3000;

    // Slot indices along the pipe.
    localparam int          SLOT_D      = 0;
    localparam int          SLOT_E      = 1;
    localparam int          SLOT_M      = 2;
    localparam int          NUM_SLOTS   = 3;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } exc_state_e;

    // Restart PC for the faulting instruction; with M empty the next sequential
    // word after the last retired-into-M instruction is the resume point.
    function automatic logic [31:0] calc_epc(
        input logic        m_valid,
        input logic        bd,
        input logic [31:0] pc,
        input logic [31:0] last_pc
    );
        logic [31:0] epc;
        if (!m_valid)
            epc = last_pc + 32'd4;
        else if (bd)
            epc = pc - 32'd4;
        else
            epc = pc;
        return epc;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline <-> exception controller signal bundle: per-stage fault reports,
// M-stage context, CP0 state in; commit strobe and redirect out.
interface exc_ctrl_if #(
    parameter int CODE_W = 5
);
    logic              stall_d;
    logic              exc_f_valid;
    logic [CODE_W-1:0] exc_f_code;
    logic              exc_d_valid;
    logic [CODE_W-1:0] exc_d_code;
    logic              exc_e_valid;
    logic [CODE_W-1:0] exc_e_code;
    logic              exc_m_valid;
    logic [CODE_W-1:0] exc_m_code;
    logic              m_valid;
    logic [31:0]       pc_m;
    logic              bd_m;
    logic              eret_m;
    logic [5:0]        hw_int;
    logic [5:0]        sr_im;
    logic              sr_ie;
    logic              sr_exl;
    logic [31:0]       epc_cp0;

    logic              exc_take;
    logic [CODE_W-1:0] exc_code;
    logic [31:0]       exc_epc;
    logic              exc_bd;
    logic              flush;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

    modport master (
        output stall_d, exc_f_valid, exc_f_code, exc_d_valid, exc_d_code,
               exc_e_valid, exc_e_code, exc_m_valid, exc_m_code,
               m_valid, pc_m, bd_m, eret_m, hw_int, sr_im, sr_ie, sr_exl, epc_cp0,
        input  exc_take, exc_code, exc_epc, exc_bd, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  stall_d, exc_f_valid, exc_f_code, exc_d_valid, exc_d_code,
               exc_e_valid, exc_e_code, exc_m_valid, exc_m_code,
               m_valid, pc_m, bd_m, eret_m, hw_int, sr_im, sr_ie, sr_exl, epc_cp0,
        output exc_take, exc_code, exc_epc, exc_bd, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_ctrl_slot.sv
// One pipeline-stage fault record (valid + code). An older fault carried in
// from upstream always beats a fault newly detected for the same instruction.
module exc_slot #(
    parameter int CODE_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic              i_in_valid,
    input  logic [CODE_W-1:0] i_in_code,
    input  logic              i_new_valid,
    input  logic [CODE_W-1:0] i_new_code,
    output logic              o_valid,
    output logic [CODE_W-1:0] o_code
);

    logic              r_valid;
    logic [CODE_W-1:0] r_code;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
            r_code  <= '0;
        end else if (i_hold) begin
            r_valid <= r_valid;
            r_code  <= r_code;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_code  <= '0;
        end else if (i_in_valid) begin
            r_valid <= 1'b1;
            r_code  <= i_in_code;
        end else if (i_new_valid) begin
            r_valid <= 1'b1;
            r_code  <= i_new_code;
        end else begin
            r_valid <= 1'b0;
            r_code  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_code  = r_code;

endmodule

// File: rtl/exc_ctrl.sv
// Precise-exception controller: tracks per-stage faults down to M, decides the
// take/eret in M and drives the CP0 commit and the pipeline flush/redirect.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
    parameter int          CODE_W  = CODE_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.slave  bus
);

    exc_state_e        r_state;
    logic [31:0]       r_last_pc;

    logic [NUM_SLOTS-1:0] w_hold;
    logic [NUM_SLOTS-1:0] w_bubble;
    logic [NUM_SLOTS-1:0] w_in_valid;
    logic [NUM_SLOTS-1:0] w_new_valid;
    logic [NUM_SLOTS-1:0] w_slot_valid;
    logic [CODE_W-1:0]    w_in_code   [NUM_SLOTS];
    logic [CODE_W-1:0]    w_new_code  [NUM_SLOTS];
    logic [CODE_W-1:0]    w_slot_code [NUM_SLOTS];

    logic              w_int_req;
    logic              w_run;
    logic              w_m_fault;
    logic              w_take;
    logic              w_eret;
    logic              w_flush;
    logic [CODE_W-1:0] w_code;
    logic [31:0]       w_epc;

    // D takes the fetch fault; E and M take the slot ahead of them merged with
    // the fault detected in the stage they are leaving.
    always_comb begin
        w_hold      = '0;
        w_bubble    = '0;
        w_in_valid  = '0;
        w_new_valid = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_in_code[i]  = '0;
            w_new_code[i] = '0;
        end

        w_hold[SLOT_D]      = bus.stall_d;
        w_in_valid[SLOT_D]  = bus.exc_f_valid;
        w_in_code[SLOT_D]   = bus.exc_f_code;

        w_bubble[SLOT_E]    = bus.stall_d;
        w_in_valid[SLOT_E]  = w_slot_valid[SLOT_D];
        w_in_code[SLOT_E]   = w_slot_code[SLOT_D];
        w_new_valid[SLOT_E] = bus.exc_d_valid;
        w_new_code[SLOT_E]  = bus.exc_d_code;

        w_in_valid[SLOT_M]  = w_slot_valid[SLOT_E];
        w_in_code[SLOT_M]   = w_slot_code[SLOT_E];
        w_new_valid[SLOT_M] = bus.exc_e_valid;
        w_new_code[SLOT_M]  = bus.exc_e_code;
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        exc_slot #(
            .CODE_W (CODE_W)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .i_clear     (w_flush),
            .i_hold      (w_hold[gi]),
            .i_bubble    (w_bubble[gi]),
            .i_in_valid  (w_in_valid[gi]),
            .i_in_code   (w_in_code[gi]),
            .i_new_valid (w_new_valid[gi]),
            .i_new_code  (w_new_code[gi]),
            .o_valid     (w_slot_valid[gi]),
            .o_code      (w_slot_code[gi])
        );
    end

    assign w_int_req = (|(bus.hw_int & bus.sr_im)) & bus.sr_ie & ~bus.sr_exl;

    // Reset gates the decision combinationally so a same-cycle take/eret is lost.
    assign w_run     = (r_state == ST_RUN) & ~reset;
    assign w_m_fault = w_slot_valid[SLOT_M] | (bus.m_valid & bus.exc_m_valid);
    assign w_take    = w_run & (w_int_req | w_m_fault);
    assign w_eret    = w_run & bus.eret_m & bus.m_valid & ~w_take;
    assign w_flush   = w_take | w_eret;

    always_comb begin
        if (w_int_req)
            w_code = CODE_W'(EXC_INT);
        else if (w_slot_valid[SLOT_M])
            w_code = w_slot_code[SLOT_M];
        else
            w_code = bus.exc_m_code;
    end

    assign w_epc = calc_epc(bus.m_valid, bus.bd_m, bus.pc_m, r_last_pc);

    assign bus.exc_take       = w_take;
    assign bus.exc_code       = w_take ? w_code : '0;
    assign bus.exc_epc        = w_take ? w_epc : 32'd0;
    assign bus.exc_bd         = w_take & bus.bd_m & bus.m_valid;
    assign bus.flush          = w_flush;
    assign bus.redirect_valid = w_flush;
    assign bus.redirect_pc    = w_take ? EXC_VEC : (w_eret ? bus.epc_cp0 : 32'd0);

    // SHADOW lasts one cycle so the redirected instruction can enter unmolested.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_last_pc <= LAST_PC_RST;
        end else begin
            if (bus.m_valid)
                r_last_pc <= {bus.pc_m[31:2], 2'b00};
            case (r_state)
                ST_RUN:    r_state <= w_flush ? ST_SHADOW : ST_RUN;
                ST_SHADOW: r_state <= ST_RUN;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: stimulus queues the expected redirect per cycle,
// a negedge monitor checks each cycle against the queue head (or all-zero).
module tb_exc_ctrl;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exc_ctrl_if #(.CODE_W(5)) bus ();

    exc_ctrl #(
        .EXC_VEC (32'h0000_4180),
        .CODE_W  (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic        take;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: one expected event per redirect cycle, otherwise outputs must be idle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            $display("cyc=%0d redirect take=%0d code=%0d epc=0x%08h bd=%0d rpc=0x%08h",
                     cyc, bus.exc_take, bus.exc_code, bus.exc_epc, bus.exc_bd, bus.redirect_pc);
            chk("take",        32'(bus.exc_take),       32'(e.take));
            chk("code",        32'(bus.exc_code),       32'(e.code));
            chk("epc",         bus.exc_epc,             e.epc);
            chk("bd",          32'(bus.exc_bd),         32'(e.bd));
            chk("flush",       32'(bus.flush),          32'd1);
            chk("redir_valid", 32'(bus.redirect_valid), 32'd1);
            chk("redir_pc",    bus.redirect_pc,         e.rpc);
        end else begin
            chk("idle_ctl", {24'd0, bus.exc_take, bus.flush, bus.redirect_valid, bus.exc_bd,
                             bus.exc_code[3:0]}, 32'd0);
            chk("idle_code4", 32'(bus.exc_code[4]), 32'd0);
            chk("idle_epc",   bus.exc_epc,          32'd0);
            chk("idle_rpc",   bus.redirect_pc,      32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset           = 1'b0;
        bus.stall_d     = 1'b0;
        bus.exc_f_valid = 1'b0; bus.exc_f_code = 5'd0;
        bus.exc_d_valid = 1'b0; bus.exc_d_code = 5'd0;
        bus.exc_e_valid = 1'b0; bus.exc_e_code = 5'd0;
        bus.exc_m_valid = 1'b0; bus.exc_m_code = 5'd0;
        bus.m_valid     = 1'b0;
        bus.pc_m        = 32'd0;
        bus.bd_m        = 1'b0;
        bus.eret_m      = 1'b0;
        bus.hw_int      = 6'd0;
        bus.sr_im       = 6'd0;
        bus.sr_ie       = 1'b0;
        bus.sr_exl      = 1'b0;
        bus.epc_cp0     = 32'd0;
    endtask

    task automatic int_on(input logic exl);
        bus.hw_int = 6'b000001;
        bus.sr_im  = 6'b000001;
        bus.sr_ie  = 1'b1;
        bus.sr_exl = exl;
    endtask

    task automatic push(input logic take, input logic [4:0] code, input logic [31:0] epc,
                        input logic bd, input logic [31:0] rpc);
        exp_t e;
        e.cyc = cyc; e.take = take; e.code = code; e.epc = epc; e.bd = bd; e.rpc = rpc;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1'b1;
        tick(); clr(); reset = 1'b1;
        tick(); clr();
        tick(); clr();

        // RI in D at 0x3008 reaches M two cycles later; younger faults on the take cycle are flushed.
        tick(); clr(); bus.exc_d_valid = 1'b1; bus.exc_d_code = 5'd10;
        tick(); clr();
        tick(); clr(); bus.m_valid = 1'b1; bus.pc_m = 32'h3008;
                bus.exc_d_valid = 1'b1; bus.exc_d_code = 5'd8;
                bus.exc_f_valid = 1'b1; bus.exc_f_code = 5'd4;
                push(1'b1, 5'd10, 32'h3008, 1'b0, 32'h4180);
        tick(); clr();
        tick(); clr();
        tick(); clr();
        tick(); clr();

        // AdEL fetch fault held through a D stall beats a later Ov in E.
        tick(); clr(); bus.exc_f_valid = 1'b1; bus.exc_f_code = 5'd4;
        tick(); clr(); bus.stall_d = 1'b1;
        tick(); clr();
        tick(); clr(); bus.exc_e_valid = 1'b1; bus.exc_e_code = 5'd12;
        tick(); clr(); bus.m_valid = 1'b1; bus.pc_m = 32'h3010;
                push(1'b1, 5'd4, 32'h3010, 1'b0, 32'h4180);
        tick(); clr();

        // Interrupt on a delay-slot instruction, shadow suppression, then EXL masking.
        tick(); clr(); int_on(1'b0); bus.m_valid = 1'b1; bus.bd_m = 1'b1; bus.pc_m = 32'h3010;
                push(1'b1, 5'd0, 32'h300C, 1'b1, 32'h4180);
        tick(); clr(); int_on(1'b0);
        tick(); clr(); int_on(1'b1); bus.m_valid = 1'b1; bus.pc_m = 32'h4180;
        tick(); clr();

        // eret with an interrupt pending behind EXL: redirect, shadow, then take.
        tick(); clr(); int_on(1'b1); bus.eret_m = 1'b1; bus.m_valid = 1'b1;
                bus.pc_m = 32'h4190; bus.epc_cp0 = 32'h3020;
                push(1'b0, 5'd0, 32'h0, 1'b0, 32'h3020);
        tick(); clr(); int_on(1'b0);
        tick(); clr(); int_on(1'b0); bus.m_valid = 1'b1; bus.pc_m = 32'h3020;
                push(1'b1, 5'd0, 32'h3020, 1'b0, 32'h4180);
        tick(); clr();

        // AdES in M together with eret: the exception wins.
        tick(); clr(); bus.m_valid = 1'b1; bus.pc_m = 32'h3030; bus.eret_m = 1'b1;
                bus.epc_cp0 = 32'h3020; bus.exc_m_valid = 1'b1; bus.exc_m_code = 5'd5;
                push(1'b1, 5'd5, 32'h3030, 1'b0, 32'h4180);
        tick(); clr();

        // Interrupt on an M bubble resumes after the last M pc.
        tick(); clr(); bus.m_valid = 1'b1; bus.pc_m = 32'h3040;
        tick(); clr(); int_on(1'b0);
                push(1'b1, 5'd0, 32'h3044, 1'b0, 32'h4180);
        tick(); clr();

        // Reset masks a same-cycle interrupt and reseeds last_pc to 0x3000.
        tick(); clr(); int_on(1'b0); reset = 1'b1;
        tick(); clr();
        tick(); clr(); int_on(1'b0);
                push(1'b1, 5'd0, 32'h3004, 1'b0, 32'h4180);
        tick(); clr();
        tick(); clr();

        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
